// File: rtl/peripheral_ahb3_spram_bridge.sv
// AHB3-Lite slave front end for a 1R/1W synchronous SRAM with byte enables.
// Decodes size/lanes, runs zero-wait reads and writes, and stalls once on read-after-write.
module peripheral_ahb3_spram_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int MEM_ABITS  = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [MEM_ABITS-1:0]    mem_waddr_o,
  output logic [HDATA_SIZE-1:0]   mem_din_o,
  output logic                    mem_we_o,
  output logic [HDATA_SIZE/8-1:0] mem_be_o,
  output logic [MEM_ABITS-1:0]    mem_raddr_o,
  input  logic [HDATA_SIZE-1:0]   mem_dout_i
);

  localparam int BW    = HDATA_SIZE / 8;
  localparam int OFS_W = $clog2(BW);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RAW, S_ERR1, S_ERR2} state_t;

  state_t               state_q, state_d;
  logic [MEM_ABITS-1:0] addr_q, addr_d;
  logic [BW-1:0]        be_q, be_d;

  logic [MEM_ABITS-1:0] haddr_word;
  logic [OFS_W-1:0]     haddr_ofs;
  logic                 accept;
  logic                 size_ok;
  logic                 unused_ok;

  // A byte lane is enabled when it falls in the same size-aligned block as the address offset.
  function automatic logic [BW-1:0] lane_mask(input logic [2:0] size, input logic [OFS_W-1:0] ofs);
    logic [BW-1:0] m;
    logic [31:0]   ofs32;
    ofs32 = {{(32-OFS_W){1'b0}}, ofs};
    for (int i = 0; i < BW; i++) begin
      m[i] = ((unsigned'(i) >> size) == (ofs32 >> size));
    end
    return m;
  endfunction

  assign haddr_word = HADDR[MEM_ABITS+OFS_W-1:OFS_W];
  assign haddr_ofs  = HADDR[OFS_W-1:0];
  assign accept     = HSEL & HREADY & HTRANS[1];
  assign size_ok    = (HSIZE <= 3'(OFS_W));
  assign unused_ok  = ^{HBURST, HPROT, HMASTLOCK, HADDR};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    if (state_q == S_RAW) begin
      state_d = S_RD;
    end else if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if (HREADY) begin
      state_d = S_IDLE;
      if (accept) begin
        if (!size_ok) begin
          state_d = S_ERR1;
        end else begin
          addr_d = haddr_word;
          be_d   = lane_mask(HSIZE, haddr_ofs);
          if (HWRITE)
            state_d = S_WR;
          // The read was launched against the pre-write word; re-read after the write commits.
          else if (state_q == S_WR && haddr_word == addr_q)
            state_d = S_RAW;
          else
            state_d = S_RD;
        end
      end
    end
  end

  assign HREADYOUT   = !(state_q == S_RAW || state_q == S_ERR1);
  assign HRESP       = (state_q == S_ERR1 || state_q == S_ERR2);
  assign HRDATA      = mem_dout_i;
  assign mem_we_o    = (state_q == S_WR);
  assign mem_be_o    = mem_we_o ? be_q : '0;
  assign mem_waddr_o = addr_q;
  assign mem_din_o   = HWDATA;
  assign mem_raddr_o = (state_q == S_RAW) ? addr_q : haddr_word;

endmodule
